input_unit: RTL

Router input port for the mesh NoC: buffers incoming flits, computes the XY output port from each head flit, and drives the request/grant handshake toward the crossbar. One instance per router input. Its `flit_o`, `port_o`, `req_o` and `grt_i` connect to slice `i` of the crossbar's `cb_i`, `port_i`, `req_i` and `grt_o`. Flow control is wormhole: once a head flit wins its route, the route holds until the tail flit leaves.

---
 rtl/noc_pkg.sv | 56 +++++
 rtl/flit_fifo.sv | 78 +++++++
 rtl/input_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// ----------------------------------------------------------------------------
// noc_pkg
// Shared types and constants for the mesh NoC router.
//   - router_i_t : flit format (head/tail markers, XY destination, payload)
//   - PORT_*     : output port encodings of the 5-port router
//   - route_xy   : dimension-ordered (X first, then Y) routing function
// ----------------------------------------------------------------------------
package noc_pkg;

    localparam int COORD_W    = 4;
    localparam int PAYLOAD_W  = 16;

    // Number of router output ports and the width of a port index.
    localparam int PORT_NUM   = 5;
    localparam int PORT_WIDTH = 3;

    localparam logic [PORT_WIDTH-1:0] PORT_L = 3'd0;
    localparam logic [PORT_WIDTH-1:0] PORT_E = 3'd1;
    localparam logic [PORT_WIDTH-1:0] PORT_W = 3'd2;
    localparam logic [PORT_WIDTH-1:0] PORT_N = 3'd3;
    localparam logic [PORT_WIDTH-1:0] PORT_S = 3'd4;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    typedef struct packed {
        logic                 head;
        logic                 tail;
        coord_t               dst;
        logic [PAYLOAD_W-1:0] payload;
    } router_i_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } iu_state_e;

    // X dimension is resolved completely before Y, which keeps the mesh
    // deadlock-free without virtual channels.
    function automatic logic [PORT_WIDTH-1:0] route_xy(
        input coord_t             dst,
        input logic [COORD_W-1:0] my_x,
        input logic [COORD_W-1:0] my_y
    );
        logic [PORT_WIDTH-1:0] port;
        if (dst.x > my_x)      port = PORT_E;
        else if (dst.x < my_x) port = PORT_W;
        else if (dst.y > my_y) port = PORT_N;
        else if (dst.y < my_y) port = PORT_S;
        else                   port = PORT_L;
        return port;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// ----------------------------------------------------------------------------
// flit_fifo
// Circular-buffer FIFO for router flits. The head entry is presented
// combinationally from the read pointer, so a flit written at edge N is
// visible on o_data right after edge N. No bypass path: a full FIFO refuses
// a write even while the same cycle pops.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_data (ignored when full)
//   i_data      : flit to write
//   i_pop       : discard the head entry (ignored when empty)
//   o_data      : head entry
//   o_empty     : no entries held
//   o_full      : DEPTH entries held
//   o_count     : number of entries held
// ----------------------------------------------------------------------------
module flit_fifo
    import noc_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = router_i_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Storage is data only; its contents are meaningless while empty, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers are power-of-two wide and wrap without explicit compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/input_unit.sv
// ----------------------------------------------------------------------------
// input_unit
// Router input port: buffers flits, routes each head flit with XY routing,
// and holds that route (wormhole) until the tail flit crosses the crossbar.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid_i   : upstream flit valid
//   in_flit_i    : upstream flit
//   in_ready_o   : FIFO has room (registered-count based)
//   flit_o       : FIFO head flit toward the crossbar
//   port_o       : output port held for the current packet
//   req_o        : crossbar request (route held and a flit is waiting)
//   grt_i        : crossbar grant vector, one bit per output port
//   err_o        : one-cycle pulse when an orphan body/tail flit is dropped
// ----------------------------------------------------------------------------
module input_unit
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MY_X  = 0,
    parameter int MY_Y  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    input  router_i_t             in_flit_i,
    output logic                  in_ready_o,
    output router_i_t             flit_o,
    output logic [PORT_WIDTH-1:0] port_o,
    output logic                  req_o,
    input  logic [PORT_NUM-1:0]   grt_i,
    output logic                  err_o
);

    localparam logic [COORD_W-1:0] L_MY_X = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] L_MY_Y = COORD_W'(MY_Y);

    iu_state_e               r_state;
    iu_state_e               w_state_nxt;
    logic [PORT_WIDTH-1:0]   r_port;
    logic [PORT_WIDTH-1:0]   w_port_nxt;

    router_i_t               w_head;
    logic                    w_empty;
    logic                    w_full;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_grant_hit;

    assign w_push     = in_valid_i && !w_full;
    assign in_ready_o = !w_full;

    flit_fifo #(
        .DEPTH (DEPTH),
        .T     (router_i_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (in_flit_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // The count is kept inside the FIFO; only empty/full are consumed here.
    logic w_count_unused;
    assign w_count_unused = ^w_count;

    assign flit_o = w_head;
    assign port_o = r_port;

    // Only the grant for the held port matters; all others are ignored.
    assign w_grant_hit = grt_i[r_port];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_port  <= PORT_L;
        end else begin
            r_state <= w_state_nxt;
            r_port  <= w_port_nxt;
        end
    end

    // req_o and err_o come only from registered state and the FIFO head, so
    // grt_i has no combinational path to any output; it only steers the pop.
    always_comb begin
        w_state_nxt = r_state;
        w_port_nxt  = r_port;
        w_pop       = 1'b0;
        req_o       = 1'b0;
        err_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (w_head.head) begin
                        // Route is latched now; the request follows next cycle.
                        w_port_nxt  = route_xy(w_head.dst, L_MY_X, L_MY_Y);
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        // Body/tail with no owning head: drop it.
                        w_pop = 1'b1;
                        err_o = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                // An empty FIFO mid-packet drops the request but keeps the route.
                req_o = !w_empty;
                if (!w_empty && w_grant_hit) begin
                    w_pop = 1'b1;
                    if (w_head.tail) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
